wb_ctrl_mw: RTL

//  Multi-lane writeback stage: the last pipeline register after MEM. Holds LANES in-order instructions as one group.

---
 rtl/wb_ctrl_mw_pkg.sv | 32 +++
 rtl/wb_ctrl_mw_load_align.sv | 31 +++
 rtl/wb_ctrl_mw.sv | 115 +++++++++++
 3 files changed

// File: rtl/wb_ctrl_mw_pkg.sv
// Shared writeback-stage types: memory op encodings and the per-lane held-instruction record.
package wb_ctrl_mw_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    MEM_NOP    = 2'd0,
    MEM_LOAD_S = 2'd1,
    MEM_LOAD_U = 2'd2,
    MEM_STORE  = 2'd3
  } mem_type_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [XLEN-1:0]   result;
    mem_type_t         mtype;
    mem_size_t         msize;
    logic [REG_AW-1:0] dest;
  } wb_lane_t;

  function automatic logic is_load(mem_type_t t);
    return (t == MEM_LOAD_S) || (t == MEM_LOAD_U);
  endfunction

endpackage

// File: rtl/wb_ctrl_mw_load_align.sv
// Load data aligner: picks the addressed byte/half out of a 32-bit word and extends it.
module load_align
  import wb_ctrl_mw_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      MEM_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      MEM_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_ctrl_mw.sv
// Multi-lane writeback stage: holds one in-order group, collects in-order load responses
// into per-lane buffers, and commits the whole group atomically to the register file.
module wb_ctrl_mw
  import wb_ctrl_mw_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned RA_W   = REG_AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_ready,
  input  logic                    allowout,
  input  logic [LANES-1:0]        mem_valid,
  input  logic [LANES*32-1:0]     mem_pc,
  input  logic [LANES*DATA_W-1:0] mem_result,
  input  mem_type_t [LANES-1:0]   mem_mem_type,
  input  mem_size_t [LANES-1:0]   mem_mem_size,
  input  logic [LANES*RA_W-1:0]   mem_dest,
  input  logic                    mmu_data_ok,
  input  logic [31:0]             mmu_rdata,
  output logic [LANES-1:0]        wb_valid,
  output logic                    wb_ready,
  output logic                    wb_stall,
  output logic [LANES-1:0]        rf_we,
  output logic [LANES*RA_W-1:0]   rf_waddr,
  output logic [LANES*DATA_W-1:0] rf_wdata,
  output logic [LANES-1:0]        wb_forwardable,
  output logic [LANES*32-1:0]     wb_pc,
  output logic [LANES*RA_W-1:0]   wb_dest,
  output logic [LANES*DATA_W-1:0] wb_result
);

  if (DATA_W != XLEN || RA_W != REG_AW) begin : g_bad_width
    $error("wb_ctrl_mw: DATA_W/RA_W must match the lane record widths");
  end

  wb_lane_t [LANES-1:0]        lane_q;
  logic [LANES-1:0]            valid_q, ld_done_q;
  logic [LANES-1:0][31:0]      ld_data_q;
  logic [LANES-1:0]            load_lane, pending, ptr_oh, lane_ok;
  logic [LANES-1:0][31:0]      raw_data, aligned;
  logic                        ptr_found;

  // Responses arrive in program order, so they always belong to the lowest pending lane.
  always_comb begin
    ptr_oh    = '0;
    ptr_found = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (pending[i] && !ptr_found) begin
        ptr_oh[i] = 1'b1;
        ptr_found = 1'b1;
      end
    end
  end

  assign wb_ready = &lane_ok;
  assign wb_stall = (|valid_q) && (!wb_ready || !allowout);
  assign wb_valid = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      ld_done_q <= '0;
    end else if (!wb_stall) begin
      valid_q   <= mem_ready ? mem_valid : '0;
      ld_done_q <= '0;
    end else if (mmu_data_ok) begin
      ld_done_q <= ld_done_q | ptr_oh;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!wb_stall && mem_ready) begin
        lane_q[i] <= '{pc:     mem_pc[i*32 +: 32],
                       result: mem_result[i*DATA_W +: DATA_W],
                       mtype:  mem_mem_type[i],
                       msize:  mem_mem_size[i],
                       dest:   mem_dest[i*RA_W +: RA_W]};
      end
      // Captured only while stalled; an unstalled cycle commits straight from the bypass.
      if (wb_stall && mmu_data_ok && ptr_oh[i]) begin
        ld_data_q[i] <= mmu_rdata;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign load_lane[i] = valid_q[i] && is_load(lane_q[i].mtype);
    assign pending[i]   = load_lane[i] && !ld_done_q[i];
    assign lane_ok[i]   = !load_lane[i] || ld_done_q[i] || (ptr_oh[i] && mmu_data_ok);
    assign raw_data[i]  = ld_done_q[i] ? ld_data_q[i] : mmu_rdata;

    load_align u_align (
      .rdata    (raw_data[i]),
      .addr     (lane_q[i].result[1:0]),
      .size     (lane_q[i].msize),
      .sign_ext (lane_q[i].mtype == MEM_LOAD_S),
      .result   (aligned[i])
    );

    assign rf_we[i]                       = allowout && wb_ready && valid_q[i] &&
                                            (lane_q[i].dest != '0);
    assign rf_waddr[i*RA_W +: RA_W]       = lane_q[i].dest;
    assign rf_wdata[i*DATA_W +: DATA_W]   = load_lane[i] ? aligned[i] : lane_q[i].result;
    assign wb_forwardable[i]              = valid_q[i] &&
                                            (!is_load(lane_q[i].mtype) || ld_done_q[i]);
    assign wb_pc[i*32 +: 32]              = lane_q[i].pc;
    assign wb_dest[i*RA_W +: RA_W]        = lane_q[i].dest;
    assign wb_result[i*DATA_W +: DATA_W]  = (load_lane[i] && ld_done_q[i]) ? aligned[i] :
                                            lane_q[i].result;
  end

endmodule
